// File: rtl/serializer_ctrl_pkg.sv
// Shared definitions for the serializer arbiter.
//   arb_state_t      : arbiter FSM states
//   MOD_ILLEGAL_1/2  : length codes the serializer silently ignores
//   TIMEOUT_DEFAULT  : default WAIT watchdog length in cycles
//   mod_is_legal()   : true when a length code will actually start a transfer
package serializer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic [3:0] MOD_ILLEGAL_1 = 4'd1;
  localparam logic [3:0] MOD_ILLEGAL_2 = 4'd2;

  localparam int TIMEOUT_DEFAULT = 32;

  // Callers zero-extend their length field so any MOD_W can be checked.
  function automatic logic mod_is_legal(input logic [31:0] m);
    return (m != 32'(MOD_ILLEGAL_1)) && (m != 32'(MOD_ILLEGAL_2));
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1 and wraps
//   grant : one-hot winner (all zero when nothing requests)
//   idx   : binary index of the winner
//   any   : at least one request is asserted
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter sharing one serializer among N_REQ requesters.
//   clk_i, srst_i    : clock, synchronous active-high reset (shared with serializer)
//   req_val_i        : per-requester request, held until accepted
//   req_data_i       : packed words, requester k at [k*DATA_W +: DATA_W]
//   req_mod_i        : packed length codes, requester k at [k*MOD_W +: MOD_W]
//   req_ready_o      : one-hot accept pulse (same cycle as arbitration)
//   req_err_o        : one-hot reject pulse (illegal length or watchdog expiry)
//   ser_data_o       : word to serializer, held outside ISSUE
//   ser_data_mod_o   : length code to serializer, forwarded unchanged
//   ser_data_val_o   : single-cycle issue strobe
//   ser_busy_i       : serializer busy
//   grant_id_o       : index of current or most recent owner
//   active_o         : high while a transfer is in ISSUE or WAIT
module serializer_arbiter
  import serializer_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int MOD_W   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [N_REQ-1:0]          req_val_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ*MOD_W-1:0]    req_mod_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          req_err_o,
  output logic [DATA_W-1:0]         ser_data_o,
  output logic [MOD_W-1:0]          ser_data_mod_o,
  output logic                      ser_data_val_o,
  input  logic                      ser_busy_i,
  output logic [$clog2(N_REQ)-1:0]  grant_id_o,
  output logic                      active_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state, state_n;
  logic [IDX_W-1:0]  ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] win_data;
  logic [MOD_W-1:0]  win_mod;
  logic              win_legal;
  logic              load;
  logic [N_REQ-1:0]  ready_c, err_c;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req_val_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    win_data = '0;
    win_mod  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        win_data = req_data_i[k*DATA_W +: DATA_W];
        win_mod  = req_mod_i[k*MOD_W +: MOD_W];
      end
    end
    win_legal = mod_is_legal(32'(win_mod));
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    load    = 1'b0;
    ready_c = '0;
    err_c   = '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (pick_any) begin
          ready_c = pick_grant;
          ptr_n   = pick_idx;
          if (win_legal) begin
            load    = 1'b1;
            state_n = ISSUE;
          end else begin
            // Serializer would ignore this length; reject instead of waiting on it.
            err_c = pick_grant;
          end
        end
      end
      ISSUE: begin
        // Busy is not examined here: it already reflects our own valid strobe.
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (!ser_busy_i) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_c   = N_REQ'(1) << grant_id_o;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready_o    = srst_i ? '0 : ready_c;
  assign req_err_o      = srst_i ? '0 : err_c;
  assign ser_data_val_o = (state == ISSUE);
  assign active_o       = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
      ptr   <= IDX_W'(N_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // Output word registers: loaded only on a legal grant.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ser_data_o     <= '0;
      ser_data_mod_o <= '0;
      grant_id_o     <= '0;
    end else if (load) begin
      ser_data_o     <= win_data;
      ser_data_mod_o <= win_mod;
      grant_id_o     <= pick_idx;
    end
  end

endmodule

// File: tb/tb_serializer_arbiter.sv
// Self-checking bench for serializer_arbiter with a behavioural serializer
// busy model. Table of arbitration vectors plus hand-written timeout and
// reset sequences; issued words are checked against a scoreboard queue.
module tb_serializer_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            srst;
  logic [N-1:0]    req_val;
  logic [N*DW-1:0] req_data;
  logic [N*MW-1:0] req_mod;
  logic [N-1:0]    req_ready, req_err;
  logic [DW-1:0]   ser_data;
  logic [MW-1:0]   ser_mod;
  logic            ser_val, ser_busy;
  logic [1:0]      grant_id;
  logic            active;
  logic            force_busy;
  logic [4:0]      rem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]    req;
    logic [N*MW-1:0] mods;
    logic [DW-1:0]   data;
    logic [N-1:0]    exp_ready;
    logic [N-1:0]    exp_err;
    int              exp_id;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
    logic [1:0]    id;
  } txn_t;

  txn_t sbq[$];
  vec_t tbl[11];

  serializer_arbiter #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW), .TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .req_val_i      (req_val),
    .req_data_i     (req_data),
    .req_mod_i      (req_mod),
    .req_ready_o    (req_ready),
    .req_err_o      (req_err),
    .ser_data_o     (ser_data),
    .ser_data_mod_o (ser_mod),
    .ser_data_val_o (ser_val),
    .ser_busy_i     (ser_busy),
    .grant_id_o     (grant_id),
    .active_o       (active)
  );

  always #5 clk = ~clk;

  // Serializer stand-in: busy while strobed and for len cycles afterwards.
  always @(posedge clk) begin
    if (srst) rem <= 5'd0;
    else if (ser_val && ser_mod != 4'd1 && ser_mod != 4'd2)
      rem <= (ser_mod == 4'd0) ? 5'd16 : 5'(ser_mod);
    else if (rem != 5'd0) rem <= rem - 5'd1;
  end
  assign ser_busy = force_busy | ser_val | (rem != 5'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [MW-1:0] m);
    return (m == 4'd0) ? 16 : int'(m);
  endfunction

  // Scoreboard and invariant monitor.
  always @(negedge clk) begin
    if (!srst && ser_val) begin
      chk("issue_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        txn_t t;
        t = sbq.pop_front();
        chk("issue_data", 32'(ser_data), 32'(t.data));
        chk("issue_mod", 32'(ser_mod), 32'(t.mod));
        chk("issue_id", 32'(grant_id), 32'(t.id));
        chk("no_overlap", 32'(rem), 32'd0);
      end
    end
    if (!srst && |req_ready && !force_busy)
      chk("grant_while_idle_ser", 32'(ser_busy), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follow one transfer from ISSUE back to IDLE, with a bounded wait.
  task automatic run_active(input int exp_id, output int n, output int err_at,
                            output int err_cnt, output logic [N-1:0] err_val);
    n = 0; err_at = -1; err_cnt = 0; err_val = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!active) break;
      n++;
      if (n == 1) chk("grant_id", 32'(grant_id), 32'(exp_id));
      if (|req_err) begin
        err_at = n;
        err_cnt++;
        err_val = req_err;
      end
    end
    chk("idle_reached", 32'(active), 32'd0);
  endtask

  task automatic drive(input logic [N-1:0] rv, input logic [N*MW-1:0] mods,
                       input logic [DW-1:0] base);
    req_val = rv;
    req_mod = mods;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = base + 16'(k);
  endtask

  function automatic logic [MW-1:0] slot_mod(input logic [N*MW-1:0] mods, input int k);
    logic [N*MW-1:0] tmp;
    tmp = mods >> (MW * k);
    return tmp[MW-1:0];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, err_at, err_cnt;
    logic [N-1:0] err_val;
    logic [MW-1:0] m;

    //            req      mods                        data      ready    err      id
    tbl[0]  = '{4'b0001, {4{4'd8}},                  16'hA5C3, 4'b0001, 4'b0000, 0};
    tbl[1]  = '{4'b1111, {4{4'd4}},                  16'h1110, 4'b0010, 4'b0000, 1};
    tbl[2]  = '{4'b1111, {4{4'd4}},                  16'h2220, 4'b0100, 4'b0000, 2};
    tbl[3]  = '{4'b1111, {4{4'd4}},                  16'h3330, 4'b1000, 4'b0000, 3};
    tbl[4]  = '{4'b1111, {4{4'd4}},                  16'h4440, 4'b0001, 4'b0000, 0};
    tbl[5]  = '{4'b0100, {4'd4, 4'd1, 4'd4, 4'd4},   16'h5550, 4'b0100, 4'b0100, 2};
    tbl[6]  = '{4'b0100, {4'd4, 4'd2, 4'd4, 4'd4},   16'h6660, 4'b0100, 4'b0100, 2};
    tbl[7]  = '{4'b1001, {4{4'd4}},                  16'h7770, 4'b1000, 4'b0000, 3};
    tbl[8]  = '{4'b0001, {4{4'd0}},                  16'hFFFF, 4'b0001, 4'b0000, 0};
    tbl[9]  = '{4'b1010, {4{4'd8}},                  16'h0F0F, 4'b0010, 4'b0000, 1};
    tbl[10] = '{4'b1001, {4{4'd8}},                  16'h3C3C, 4'b1000, 4'b0000, 3};

    srst = 1'b1; force_busy = 1'b0;
    req_val = '0; req_data = '0; req_mod = '0;
    step(); step();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    chk("rst_val", 32'(ser_val), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_data", 32'(ser_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    step();
    srst = 1'b0;

    for (int r = 0; r < 11; r++) begin
      step();
      drive(tbl[r].req, tbl[r].mods, tbl[r].data);
      @(negedge clk);
      chk($sformatf("ready_r%0d", r), 32'(req_ready), 32'(tbl[r].exp_ready));
      chk($sformatf("err_r%0d", r), 32'(req_err), 32'(tbl[r].exp_err));
      m = slot_mod(tbl[r].mods, tbl[r].exp_id);
      if (tbl[r].exp_err == '0)
        sbq.push_back('{tbl[r].data + 16'(tbl[r].exp_id), m, 2'(tbl[r].exp_id)});
      step();
      req_val = '0;
      if (tbl[r].exp_err == '0) begin
        run_active(tbl[r].exp_id, n, err_at, err_cnt, err_val);
        chk($sformatf("active_cycles_r%0d", r), 32'(n), 32'(len_of(m) + 2));
        chk($sformatf("no_err_r%0d", r), 32'(err_cnt), 32'd0);
      end else begin
        @(negedge clk);
        chk($sformatf("stay_idle_r%0d", r), 32'(active), 32'd0);
      end
    end

    // Watchdog: busy stuck high, requester 1 (pointer is at 3).
    step();
    force_busy = 1'b1;
    drive(4'b0010, {4{4'd8}}, 16'hBEE0);
    @(negedge clk);
    chk("to_ready", 32'(req_ready), 32'b0010);
    sbq.push_back('{16'hBEE1, 4'd8, 2'd1});
    step();
    req_val = '0;
    run_active(1, n, err_at, err_cnt, err_val);
    chk("to_active_cycles", 32'(n), 32'(TO + 1));
    chk("to_err_cycle", 32'(err_at), 32'(TO + 1));
    chk("to_err_count", 32'(err_cnt), 32'd1);
    chk("to_err_val", 32'(err_val), 32'b0010);
    force_busy = 1'b0;
    step();
    drive(4'b0001, {4{4'd4}}, 16'hC000);
    @(negedge clk);
    chk("after_to_ready", 32'(req_ready), 32'b0001);
    sbq.push_back('{16'hC000, 4'd4, 2'd0});
    step();
    req_val = '0;
    run_active(0, n, err_at, err_cnt, err_val);
    chk("after_to_cycles", 32'(n), 32'd6);

    // Reset in WAIT with busy high.
    step();
    force_busy = 1'b1;
    drive(4'b0100, {4{4'd8}}, 16'hD000);
    @(negedge clk);
    chk("rw_ready", 32'(req_ready), 32'b0100);
    sbq.push_back('{16'hD002, 4'd8, 2'd2});
    step();
    req_val = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rw_in_wait", 32'(active & ~ser_val), 32'd1);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    @(negedge clk);
    chk("rw_ready0", 32'(req_ready), 32'd0);
    chk("rw_err0", 32'(req_err), 32'd0);
    chk("rw_val0", 32'(ser_val), 32'd0);
    chk("rw_active0", 32'(active), 32'd0);
    chk("rw_data0", 32'(ser_data), 32'd0);
    chk("rw_mod0", 32'(ser_mod), 32'd0);
    chk("rw_grant0", 32'(grant_id), 32'd0);
    force_busy = 1'b0;
    step();
    drive(4'b1111, {4{4'd4}}, 16'hE000);
    @(negedge clk);
    chk("rw_resume_ready", 32'(req_ready), 32'b0001);
    sbq.push_back('{16'hE000, 4'd4, 2'd0});
    step();
    req_val = '0;
    run_active(0, n, err_at, err_cnt, err_val);
    chk("rw_resume_cycles", 32'(n), 32'd6);

    step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serializer_arbiter.md
Name: serializer_arbiter

Overview:
- Shares one 16-bit serializer among N_REQ requesters using round-robin arbitration.
- Accepts one word per grant and issues it to the serializer as a single-cycle valid pulse.
- Holds off further issues until the serializer's busy output drops, or until a watchdog expires.
- Filters illegal lengths (data_mod 1 and 2, which the serializer ignores) so the block never waits on a transfer that will not start.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, word width forwarded to the serializer
- MOD_W, 4, length field width (0 encodes full word)
- TIMEOUT, 32, max WAIT cycles before forced return to IDLE

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous reset, active-high
- req_val_i  in  N_REQ  per-requester request; held until req_ready_o
- req_data_i  in  N_REQ*DATA_W  packed words; requester k at bits [k*DATA_W +: DATA_W]
- req_mod_i  in  N_REQ*MOD_W  packed length fields; requester k at bits [k*MOD_W +: MOD_W]
- req_ready_o  out  N_REQ  one-hot, one-cycle accept pulse
- req_err_o  out  N_REQ  one-hot, one-cycle reject pulse (illegal mod, or timeout)
- ser_data_o  out  DATA_W  to serializer data_i
- ser_data_mod_o  out  MOD_W  to serializer data_mod_i
- ser_data_val_o  out  1  to serializer data_val_i
- ser_busy_i  in  1  from serializer busy_o
- grant_id_o  out  $clog2(N_REQ)  index of current or last owner
- active_o  out  1  high in ISSUE and WAIT

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant pointer = N_REQ-1, so requester 0 has first priority.
- Reset mid-transfer aborts immediately. The serializer shares srst_i. No err pulse is raised for the aborted word.
- States: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - Winner is the first asserted req_val_i searching from pointer+1 upward, wrapping modulo N_REQ.
  - If none is asserted, stay in IDLE.
- IDLE, legal winner (mod not 1 or 2):
  - Pulse req_ready_o[k].
  - Latch data and mod into output registers; set grant_id_o=k.
  - Pointer=k; go to ISSUE.
- IDLE, illegal winner (mod 1 or 2):
  - Pulse req_ready_o[k] and req_err_o[k] together.
  - Pointer=k; stay in IDLE; nothing is issued.
- ISSUE: ser_data_val_o=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - ser_data_val_o=0.
  - If ser_busy_i=0, go to IDLE.
  - Otherwise increment the timeout counter (reset to 0 on entering WAIT).
  - When the counter reaches TIMEOUT-1 with busy still high, pulse req_err_o[grant_id_o] and go to IDLE.
- Latency: request asserted in cycle 0 (IDLE) → ready in cycle 0 → ser_data_val_o in cycle 1 → earliest next grant 1 cycle after busy falls.
  - ser_busy_i sampled during ISSUE is ignored, because the serializer's busy includes its own data_val_i.
- ser_data_o and ser_data_mod_o hold their value outside ISSUE; the serializer does not sample them then.
- A requester deasserting req_val_i before ready is legal: the request is withdrawn and no grant is made.
- Simultaneous requests from all N_REQ are served in strict rotation, with no requester starved.
- mod=0 is forwarded unchanged (full word); the arbiter performs no length arithmetic.

Decomposition:
- Package serializer_ctrl_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT}
  - constants MOD_ILLEGAL_1=4'd1 and MOD_ILLEGAL_2=4'd2
  - function mod_is_legal()
  - default TIMEOUT
- Sub-module rr_picker (combinational): inputs req vector and pointer; outputs one-hot grant, index and any-valid.
- serializer_arbiter holds the FSM, the latches and the timeout counter.
- Bench top instantiates serializer_arbiter plus the existing serializer.

Test Plan:
1. Single request: req_val_i=0001, data=16'hA5C3, mod=8 → ready[0] in cycle 0, ser_data_val_o for 1 cycle with A5C3/8, grant_id_o=0, returns to IDLE after busy falls.
2. All four requesting, each with mod=4 → grants in order 0,1,2,3,0, one ready pulse each, never two serializer transfers overlapping.
3. Requester 2 with mod=1, then mod=2 → ready[2] and err[2] pulse together, ser_data_val_o never asserts, pointer=2, requester 3 served next.
4. ser_busy_i forced high with TIMEOUT=32 → err[k] pulses in WAIT cycle 31, FSM returns to IDLE, next request is granted.
5. srst_i asserted in WAIT with busy high → next cycle all outputs 0, pointer=N_REQ-1, requester 0 wins when requests resume.
6. mod=0 with data=16'hFFFF → forwarded unchanged; serializer busy observed, arbiter waits for it to fall before the next grant.
